mem_access_ctrl: RTL and testbench

//  Load/store access controller between execute and load-data extraction stages.

---
 rtl/mem_access_ctrl_if.sv | 40 ++++
 rtl/mem_access_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Request, data-memory bus and response signals of the load/store access controller.
interface mem_access_ctrl_if;
    // request channel from execute
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    // single-port data-memory bus
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    // response channel to load-data extraction
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_err;
    logic        busy;

    // requester / memory side
    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  rsp_valid, rsp_data, rsp_err, busy
    );

    // controller side
    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output rsp_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store access controller: one request per handshake onto a single-port
// data-memory bus, with lane alignment, byte enables, error and timeout flags.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_ctrl_if.slave  bus
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ALIGN   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             we_q;
    logic [1:0]       off_q;
    logic             req_ready_q;
    logic             busy_q;
    logic             mem_req_q;
    logic             mem_we_q;
    logic [31:0]      mem_addr_q;
    logic [3:0]       mem_be_q;
    logic [31:0]      mem_wdata_q;
    logic             rsp_valid_q;
    logic [31:0]      rsp_data_q;
    logic [1:0]       rsp_err_q;

    logic             misaligned_c;
    logic [3:0]       be_c;
    logic [31:0]      wdata_c;
    logic             done_c;
    logic [31:0]      load_data_c;

    // Decode the incoming request: alignment check, lane enables, replicated store data.
    always_comb begin
        misaligned_c = 1'b0;
        be_c         = 4'b1111;
        wdata_c      = bus.req_wdata;
        case (bus.req_size)
            2'd0: begin
                be_c    = 4'b0001 << bus.req_addr[1:0];
                wdata_c = {4{bus.req_wdata[7:0]}};
            end
            2'd1: begin
                misaligned_c = bus.req_addr[0];
                be_c         = 4'b0011 << bus.req_addr[1:0];
                wdata_c      = {2{bus.req_wdata[15:0]}};
            end
            2'd2: begin
                misaligned_c = (bus.req_addr[1:0] != 2'b00);
            end
            default: begin
                misaligned_c = 1'b1;
            end
        endcase
    end

    // Completion of the outstanding access this cycle, and the load word shifted to the addressed byte.
    always_comb begin
        done_c      = ((state_q == ST_ISSUE) && bus.mem_gnt && (we_q || bus.mem_rvalid))
                   || ((state_q == ST_WAIT) && bus.mem_rvalid);
        load_data_c = bus.mem_rdata >> {off_q, 3'b000};
    end

    // Access FSM with all bus and response outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            off_q       <= 2'b00;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= ERR_OK;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        we_q        <= bus.req_we;
                        off_q       <= bus.req_addr[1:0];
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (misaligned_c) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= ERR_ALIGN;
                            rsp_data_q  <= '0;
                        end else begin
                            state_q     <= ST_ISSUE;
                            cnt_q       <= '0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= bus.req_we;
                            mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
                            mem_be_q    <= bus.req_we ? be_c : 4'b0000;
                            mem_wdata_q <= bus.req_we ? wdata_c : 32'd0;
                        end
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    if (done_c) begin
                        state_q     <= ST_RESP;
                        mem_req_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= ERR_OK;
                        rsp_data_q  <= we_q ? 32'd0 : load_data_c;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= ST_RESP;
                        mem_req_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= ERR_TIMEOUT;
                        rsp_data_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if ((state_q == ST_ISSUE) && bus.mem_gnt) begin
                            state_q   <= ST_WAIT;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.busy      = busy_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus random transactions
// against a cycle-count reference model of the access rules.
module tb_mem_access_ctrl;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request with a scripted memory responder; expectations come from the access rules.
    task automatic run_txn(input logic we, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                           input logic [31:0] rdata, input string name);
        bit          mis;
        int          off;
        int          tc;
        int          t_rsp;
        int          req_last;
        int          w;
        logic [3:0]  be_exp;
        logic [31:0] wd_exp;
        logic [31:0] rd_exp;
        logic [1:0]  err_exp;

        off = int'(addr[1:0]);
        mis = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && off != 0);
        if (!we)              be_exp = 4'h0;
        else if (size == 2'd0) be_exp = 4'(1 << off);
        else if (size == 2'd1) be_exp = 4'(3 << off);
        else                   be_exp = 4'hF;
        if (size == 2'd0)      wd_exp = 32'(wdata[7:0]) * 32'h0101_0101;
        else if (size == 2'd1) wd_exp = 32'(wdata[15:0]) * 32'h0001_0001;
        else                   wd_exp = wdata;
        tc = we ? gnt_dly : gnt_dly + rv_dly;
        if (mis) begin
            t_rsp = 0; err_exp = 2'd1; rd_exp = 32'd0; req_last = -1;
        end else if (tc <= TO - 1) begin
            t_rsp = tc + 1; err_exp = 2'd0; rd_exp = we ? 32'd0 : (rdata >> (8 * off));
            req_last = gnt_dly;
        end else begin
            t_rsp = TO; err_exp = 2'd2; rd_exp = 32'd0;
            req_last = (gnt_dly < TO - 1) ? gnt_dly : TO - 1;
        end

        w = 0;
        while (bus.req_ready !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        chk({name, "_ready"}, 32'(bus.req_ready), 32'd1);

        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = size;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        step();
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;

        for (int t = 0; t <= t_rsp + 1; t++) begin
            chk({name, "_mem_req"}, 32'(bus.mem_req), 32'(t <= req_last));
            if (t <= req_last) begin
                chk({name, "_mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
                chk({name, "_mem_we"}, 32'(bus.mem_we), 32'(we));
                chk({name, "_mem_be"}, 32'(bus.mem_be), 32'(be_exp));
                if (we) chk({name, "_mem_wdata"}, bus.mem_wdata, wd_exp);
            end
            chk({name, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(t == t_rsp));
            chk({name, "_busy"}, 32'(bus.busy), 32'(t <= t_rsp));
            chk({name, "_req_ready"}, 32'(bus.req_ready), 32'(t > t_rsp));
            if (t == t_rsp) begin
                chk({name, "_rsp_data"}, bus.rsp_data, rd_exp);
                chk({name, "_rsp_err"}, 32'(bus.rsp_err), 32'(err_exp));
            end
            bus.mem_gnt    = (t == gnt_dly);
            bus.mem_rvalid = !we && (t == gnt_dly + rv_dly);
            bus.mem_rdata  = bus.mem_rvalid ? rdata : $urandom;
            step();
        end
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rsize;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'd0;

        // reset values
        step();
        step();
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        rst = 1'b0;
        step();

        // load byte at 0x103, grant and data in the same cycle
        run_txn(1'b0, 2'd0, 32'h0000_0103, 32'd0, 0, 0, 32'hAABB_CCDD, "t1_ldb");
        // store half at 0x202, grant after three cycles of request
        run_txn(1'b1, 2'd1, 32'h0000_0202, 32'h0000_1234, 3, 0, 32'd0, "t2_sth");
        // misaligned word load
        run_txn(1'b0, 2'd2, 32'h0000_0006, 32'd0, 0, 0, 32'h1111_1111, "t3_mis");
        // illegal size store
        run_txn(1'b1, 2'd3, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 32'd0, "t3_ill");
        // grant without read data: timeout
        run_txn(1'b0, 2'd2, 32'h0000_0040, 32'd0, 0, 100, 32'h5555_5555, "t4_to");
        // late read data after the timeout must be ignored
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hCAFE_F00D;
        step();
        step();
        chk("t4_late_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("t4_late_req_ready", 32'(bus.req_ready), 32'd1);
        chk("t4_late_rsp_err", 32'(bus.rsp_err), 32'd2);
        bus.mem_rvalid = 1'b0;
        run_txn(1'b0, 2'd1, 32'h0000_0042, 32'd0, 1, 2, 32'h8765_4321, "t4_next");
        // store whose grant never comes in time
        run_txn(1'b1, 2'd2, 32'h0000_0080, 32'h0BAD_F00D, 20, 0, 32'd0, "t4_sto");
        // completion on the last counted cycle wins over the timeout
        run_txn(1'b0, 2'd0, 32'h0000_0091, 32'd0, 3, TO - 4, 32'h00C3_0000, "t4_edge");

        // random traffic
        for (int i = 0; i < 40; i++) begin
            rsize = 2'($urandom_range(0, 3));
            run_txn(1'($urandom_range(0, 1)), rsize, $urandom, $urandom,
                    $urandom_range(0, 9), $urandom_range(0, 4), $urandom, "rnd");
        end

        // asynchronous reset while waiting for read data
        while (bus.req_ready !== 1'b1) step();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'd2;
        bus.req_addr  = 32'h0000_0100;
        step();
        bus.req_valid = 1'b0;
        bus.mem_gnt   = 1'b1;
        step();
        bus.mem_gnt   = 1'b0;
        step();
        chk("t5_wait_busy", 32'(bus.busy), 32'd1);
        chk("t5_wait_mem_req", 32'(bus.mem_req), 32'd0);
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", 32'(bus.busy), 32'd0);
        chk("t5_rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("t5_rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("t5_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1234_5678;
        step();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t5_post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("t5_post_busy", 32'(bus.busy), 32'd0);
            step();
        end
        bus.mem_rvalid = 1'b0;
        run_txn(1'b1, 2'd0, 32'h0000_0301, 32'h0000_00A5, 0, 0, 32'd0, "t5_next");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
